instruction_register: RTL and testbench

INSTRUCTION_REGISTER -- requirements
Module: instruction_register

---
 rtl/instruction_register_pkg.sv | 16 +
 rtl/instruction_register.sv | 72 +++++++
 tb/tb_instruction_register.sv | 134 +++++++++++++
 3 files changed

// File: rtl/instruction_register_pkg.sv
// Shared constants for the instruction register: byte and immediate widths,
// plus the encoding of the slot index that tracks which byte comes next.
package instruction_register_pkg;

  localparam int BYTE_W = 8;
  localparam int IMM_W  = 16;

  // Slot that the next accepted byte lands in; IDX_DONE means all three are in.
  typedef enum logic [1:0] {
    IDX_OPCODE = 2'd0,
    IDX_IMM_LO = 2'd1,
    IDX_IMM_HI = 2'd2,
    IDX_DONE   = 2'd3
  } idx_e;

endpackage : instruction_register_pkg

// File: rtl/instruction_register.sv
// Instruction register: assembles an opcode byte followed by a little-endian
// 16-bit immediate from a byte-wide memory return stream. Capture stops once
// all three bytes are in and only restarts on clear or rst.
module instruction_register
  import instruction_register_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [BYTE_W-1:0] data,
  input  logic              mem_ack,
  input  logic              hold,
  input  logic              clear,
  output logic [BYTE_W-1:0] opcode_o,
  output logic [IMM_W-1:0]  immediate
);

  // idx: slot selector for the next byte.
  idx_e              idx_q, idx_d;
  logic [BYTE_W-1:0] opcode_q, opcode_d;
  logic [IMM_W-1:0]  imm_q, imm_d;

  // Next-state: clear beats hold, hold beats mem_ack; a complete instruction
  // ignores further acks rather than wrapping round to the opcode slot.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned
    // (an unassigned path in always_comb would infer a latch).
    idx_d    = idx_q;
    opcode_d = opcode_q;
    imm_d    = imm_q;
    if (clear) begin
      idx_d    = IDX_OPCODE;
      opcode_d = '0;
      imm_d    = '0;
    end else if (!hold && mem_ack) begin
      case (idx_q)
        IDX_OPCODE: begin
          opcode_d = data;
          idx_d    = IDX_IMM_LO;
        end
        IDX_IMM_LO: begin
          imm_d[BYTE_W-1:0] = data;
          idx_d             = IDX_IMM_HI;
        end
        IDX_IMM_HI: begin
          imm_d[IMM_W-1:BYTE_W] = data;
          idx_d                 = IDX_DONE;
        end
        IDX_DONE: begin
          idx_d = IDX_DONE;
        end
      endcase
    end
  end

  // State register with synchronous active-high reset that overrides all inputs.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every flop samples the pre-edge values.
    if (rst) begin
      idx_q    <= IDX_OPCODE;
      opcode_q <= '0;
      imm_q    <= '0;
    end else begin
      idx_q    <= idx_d;
      opcode_q <= opcode_d;
      imm_q    <= imm_d;
    end
  end

  assign opcode_o  = opcode_q;
  assign immediate = imm_q;

endmodule : instruction_register

// File: tb/tb_instruction_register.sv
// Self-checking bench for instruction_register. The driver issues one
// directed vector per cycle and queues the hand-computed post-edge state;
// an independent monitor samples just after each rising edge and compares.
module tb_instruction_register;

  logic        clk = 1'b0;
  logic        rst, mem_ack, hold, clear;
  logic [7:0]  data;
  logic [7:0]  opcode_o;
  logic [15:0] immediate;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic [1:0]  idx;
    logic [7:0]  op;
    logic [15:0] imm;
    string       name;
  } exp_t;

  exp_t sb_q[$];

  instruction_register dut (
    .clk       (clk),
    .rst       (rst),
    .data      (data),
    .mem_ack   (mem_ack),
    .hold      (hold),
    .clear     (clear),
    .opcode_o  (opcode_o),
    .immediate (immediate)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Drive one cycle of inputs and queue the state expected after the next edge.
  task automatic step(input logic r, input logic c, input logic h, input logic a,
                      input logic [7:0] d, input logic [1:0] e_idx,
                      input logic [7:0] e_op, input logic [15:0] e_imm,
                      input string name);
    exp_t e;
    @(negedge clk);
    rst = r; clear = c; hold = h; mem_ack = a; data = d;
    e.idx = e_idx; e.op = e_op; e.imm = e_imm; e.name = name;
    sb_q.push_back(e);
  endtask

  // Monitor: one expected entry is consumed per rising edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        check({e.name, ".idx"},       {14'd0, dut.idx_q}, {14'd0, e.idx});
        check({e.name, ".opcode"},    {8'd0, opcode_o},   {8'd0, e.op});
        check({e.name, ".immediate"}, immediate,          e.imm);
      end
    end
  end

  initial begin
    int budget;
    rst = 1'b1; clear = 1'b0; hold = 1'b0; mem_ack = 1'b0; data = 8'h00;

    // Reset held for two edges, then released with idle inputs.
    step(1, 0, 0, 0, 8'h00, 0, 8'h00, 16'h0000, "rst_0");
    step(1, 0, 0, 1, 8'hEE, 0, 8'h00, 16'h0000, "rst_1");
    for (int i = 0; i < 2; i++) step(0, 0, 0, 0, 8'h5A, 0, 8'h00, 16'h0000, "post_rst");

    // Full capture with 5-cycle idle gaps; outputs stable through gaps.
    step(0, 0, 0, 1, 8'h32, 1, 8'h32, 16'h0000, "cap_op");
    for (int i = 0; i < 5; i++) step(0, 0, 0, 0, 8'hFF, 1, 8'h32, 16'h0000, "gap1");
    step(0, 0, 0, 1, 8'h21, 2, 8'h32, 16'h0021, "cap_lo");
    for (int i = 0; i < 5; i++) step(0, 0, 0, 0, 8'hFF, 2, 8'h32, 16'h0021, "gap2");
    step(0, 0, 0, 1, 8'h15, 3, 8'h32, 16'h1521, "cap_hi");
    for (int i = 0; i < 5; i++) step(0, 0, 0, 0, 8'hFF, 3, 8'h32, 16'h1521, "gap3");

    // Hold at complete, then an unheld ack at complete: no wrap.
    step(0, 0, 1, 1, 8'h24, 3, 8'h32, 16'h1521, "hold_done");
    step(0, 0, 0, 1, 8'h99, 3, 8'h32, 16'h1521, "ack_done");

    // Clear beats hold and mem_ack; next ack starts a fresh capture.
    step(0, 1, 1, 1, 8'h55, 0, 8'h00, 16'h0000, "clear_prio");
    step(0, 0, 0, 1, 8'h7E, 1, 8'h7E, 16'h0000, "after_clear");

    // Back-to-back acks, and a fourth that must change nothing.
    step(0, 1, 0, 0, 8'h00, 0, 8'h00, 16'h0000, "clear2");
    step(0, 0, 0, 1, 8'hA1, 1, 8'hA1, 16'h0000, "b2b_0");
    step(0, 0, 0, 1, 8'hB2, 2, 8'hA1, 16'h00B2, "b2b_1");
    step(0, 0, 0, 1, 8'hC3, 3, 8'hA1, 16'hC3B2, "b2b_2");
    step(0, 0, 0, 1, 8'hD4, 3, 8'hA1, 16'hC3B2, "b2b_3");

    // Hold at the opcode slot and plain idle after clear.
    step(0, 1, 0, 1, 8'h66, 0, 8'h00, 16'h0000, "clear3");
    step(0, 0, 1, 1, 8'h11, 0, 8'h00, 16'h0000, "hold_idx0");
    step(0, 0, 0, 0, 8'hFF, 0, 8'h00, 16'h0000, "idle_idx0");

    // Mid-capture reset at idx=2, with other inputs active.
    step(0, 0, 0, 1, 8'h10, 1, 8'h10, 16'h0000, "mid_op");
    step(0, 0, 0, 1, 8'h20, 2, 8'h10, 16'h0020, "mid_lo");
    step(1, 0, 1, 1, 8'h30, 0, 8'h00, 16'h0000, "mid_rst");
    step(0, 0, 0, 1, 8'h40, 1, 8'h40, 16'h0000, "post_mid");
    step(0, 0, 1, 1, 8'h50, 1, 8'h40, 16'h0000, "hold_idx1");
    step(0, 0, 0, 0, 8'h00, 1, 8'h40, 16'h0000, "final_idle");

    // Drain the scoreboard within a bounded number of cycles.
    budget = 0;
    while (sb_q.size() > 0 && budget < 20) begin
      @(posedge clk);
      budget++;
    end
    #2;
    n_cmp++;
    if (sb_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: %0d entries left, expected 0", sb_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule : tb_instruction_register
